// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: valid/ready byte in, start/data/parity/stop serial frame out
module uart_tx #(
  parameter int CLKS_PER_BIT = 56,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;
  logic          par_bit;

  logic bit_end;
  logic last_stop;
  logic accept;

  assign bit_end   = (bit_cnt == CNT_LAST);
  assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;
  assign tx_ready  = (state == IDLE) || (state == STOP && last_stop && bit_end);
  assign accept    = tx_valid && tx_ready;
  assign tx_busy   = (state != IDLE);

  // Parity is captured at accept time because the shift register is consumed by DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + CW'(1);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            state   <= START;
            tx      <= 1'b0;
            shift   <= tx_data;
            par_bit <= (PARITY == 2) ? ^tx_data : ~^tx_data;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              tx_done <= 1'b1;
              if (accept) begin
                state   <= START;
                tx      <= 1'b0;
                shift   <= tx_data;
                par_bit <= (PARITY == 2) ? ^tx_data : ~^tx_data;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized bench for uart_tx: 8N1 and even-parity/2-stop instances vs frame model
module tb_uart_tx;
  localparam int N = 56;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  bit         sel = 1'b0;

  logic ready_a, tx_a, busy_a, done_a;
  logic ready_b, tx_b, busy_b, done_b;
  logic m_ready, m_tx, m_busy, m_done;

  int total = 0;
  int bad = 0;

  uart_tx #(.CLKS_PER_BIT(N)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid && !sel),
    .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(N), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid && sel),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  assign m_ready = sel ? ready_b : ready_a;
  assign m_tx    = sel ? tx_b    : tx_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  // Expected serial bit sequence of one frame, from the frame format rules.
  task automatic build_frame(input logic [7:0] d, output logic fb[12], output int nb);
    int ones = 0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb[1 + i] = d[i];
      ones += int'(d[i]);
    end
    nb = 9;
    if (sel) begin
      fb[nb] = ((ones % 2) == 1);
      nb++;
    end
    for (int s = 0; s < (sel ? 2 : 1); s++) begin
      fb[nb] = 1'b1;
      nb++;
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the final stop edge.
  task automatic send(input logic [7:0] d, input bit prev_chained, input bit next_chain,
                      input logic [7:0] nd);
    logic fb[12];
    int   nb;
    int   len;
    build_frame(d, fb, nb);
    len = nb * N;
    if (!prev_chained) begin
      check_eq("ready_before_accept", m_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < len; k++) begin
      check_eq("tx_bit", m_tx, fb[k / N]);
      check_eq("busy", m_busy, 1);
      check_eq("ready", m_ready, (k == len - 1));
      check_eq("done", m_done, (k == 0 && prev_chained));
      if (k == len - 1) begin
        tx_valid = next_chain;
        tx_data  = nd;
      end else begin
        tx_valid = next_chain ? 1'b1 : 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end
      @(negedge clk);
    end
    if (!next_chain) begin
      check_eq("done_end", m_done, 1);
      check_eq("busy_end", m_busy, 0);
      check_eq("ready_end", m_ready, 1);
      check_eq("tx_end", m_tx, 1);
      tx_valid = 1'b0;
    end
  endtask

  task automatic reset_mid(input logic [7:0] d, input int bitpos);
    check_eq("ready_before_rmid", m_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat ((1 + bitpos) * N + N / 2) @(negedge clk);
    check_eq("tx_before_rst", m_tx, d[bitpos]);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_tx", m_tx, 1);
    check_eq("rst_busy", m_busy, 0);
    check_eq("rst_ready", m_ready, 1);
    check_eq("rst_done", m_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_hold_done", m_done, 0);
      check_eq("rst_hold_tx", m_tx, 1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", m_done, 0);
      check_eq("post_rst_busy", m_busy, 0);
    end
    send(8'($urandom), 0, 0, 8'h00);
  endtask

  initial begin
    bit chained;
    bit nxt;
    logic [7:0] cur;
    logic [7:0] nd;
    logic [7:0] loop_bytes [4];

    #1 rst = 1'b1;
    #2;
    check_eq("reset_tx", tx_a, 1);
    check_eq("reset_ready", ready_a, 1);
    check_eq("reset_busy", busy_a, 0);
    check_eq("reset_done", done_a, 0);
    check_eq("reset_tx_b", tx_b, 1);
    #97;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_tx", m_tx, 1);
      check_eq("idle_ready", m_ready, 1);
      check_eq("idle_busy", m_busy, 0);
      check_eq("idle_done", m_done, 0);
    end

    sel = 1'b0;
    send(8'h55, 0, 0, 8'h00);
    loop_bytes = '{8'h12, 8'h34, 8'hA5, 8'hFF};
    for (int i = 0; i < 4; i++) send(loop_bytes[i], 0, 0, 8'h00);
    send(8'h00, 0, 1, 8'hFF);
    send(8'hFF, 1, 0, 8'h00);

    sel = 1'b1;
    @(negedge clk);
    send(8'h07, 0, 0, 8'h00);
    send(8'h00, 0, 1, 8'h80);
    send(8'h80, 1, 0, 8'h00);

    chained = 1'b0;
    cur = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      if (!chained) begin
        sel = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      nxt = (i != 9) && ($urandom_range(0, 2) == 0);
      nd  = 8'($urandom);
      send(cur, chained, nxt, nd);
      chained = nxt;
      cur = nd;
    end

    sel = 1'b0;
    @(negedge clk);
    reset_mid(8'hAA, 3);
    sel = 1'b1;
    @(negedge clk);
    reset_mid(8'hAA, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
